pattern_fb_writer: RTL and testbench



---
 rtl/pattern_fb_writer.sv | 183 ++++++++++++++++++
 tb/tb_pattern_fb_writer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_fb_writer.sv
// Purpose: Wishbone master that writes a selectable test pattern into the framebuffer, one pixel per ack.
// Latency: first write is presented one cycle after enable is seen in IDLE; back-to-back acks advance every cycle.
// Backpressure: adr/dat_ms hold while stb=1 and ack=0; cyc drops for one cycle every BURST writes so the VGA reader can be granted.
module pattern_fb_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int          BURST     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    output logic        busy,
    output logic        frame_done
);

    localparam int NPIX  = HDISP * VDISP;
    localparam int BARPX = HDISP / 8;
    localparam int XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int IW    = (NPIX  > 1) ? $clog2(NPIX)  : 1;
    localparam int PW    = (BARPX > 1) ? $clog2(BARPX) : 1;
    localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAUSE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [IW-1:0]  r_idx;
    logic [BW-1:0]  r_burst_cnt;
    logic [2:0]     r_bar;
    logic [PW-1:0]  r_bar_px;
    logic [1:0]     r_mode;
    logic [7:0]     r_frame_cnt;
    logic [31:0]    r_adr;
    logic [23:0]    r_dat;
    logic           r_frame_done;

    logic           w_last_x;
    logic           w_last_px;
    logic           w_burst_end;
    logic           w_bar_end;
    logic [XW-1:0]  w_nx;
    logic [YW-1:0]  w_ny;
    logic [IW-1:0]  w_nidx;
    logic [2:0]     w_nbar;
    logic [PW-1:0]  w_nbar_px;

    // RGB for one pixel; bar index comes from the running bar counter so no divider is needed
    function automatic logic [23:0] f_pattern(input logic [7:0] px, input logic [3:0] py,
                                              input logic [2:0] bar, input logic [1:0] m,
                                              input logic [7:0] fc);
        logic [23:0] rgb;
        rgb = 24'h000000;
        case (m)
            2'd0: rgb = (px[3:0] == 4'd0 || py == 4'd0) ? 24'hFFFFFF : 24'h000000;
            2'd1: begin
                case (bar)
                    3'd0:    rgb = 24'hFFFFFF;
                    3'd1:    rgb = 24'hFFFF00;
                    3'd2:    rgb = 24'h00FFFF;
                    3'd3:    rgb = 24'h00FF00;
                    3'd4:    rgb = 24'hFF00FF;
                    3'd5:    rgb = 24'hFF0000;
                    3'd6:    rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            2'd2:    rgb = {px, px, px};
            default: rgb = {fc, fc, fc};
        endcase
        return rgb;
    endfunction

    assign w_last_x    = (r_x == XW'(HDISP - 1));
    assign w_last_px   = w_last_x && (r_y == YW'(VDISP - 1));
    assign w_burst_end = (r_burst_cnt == BW'(BURST - 1));
    assign w_bar_end   = (r_bar_px == PW'(BARPX - 1));
    assign w_nx        = w_last_x ? '0 : r_x + 1'b1;
    assign w_ny        = w_last_x ? r_y + 1'b1 : r_y;
    assign w_nidx      = r_idx + 1'b1;
    assign w_nbar_px   = (w_last_x || w_bar_end) ? '0 : r_bar_px + 1'b1;
    assign w_nbar      = w_last_x ? 3'd0 : (w_bar_end ? r_bar + 3'd1 : r_bar);

    assign cyc        = (r_state == S_WRITE);
    assign stb        = cyc;
    assign we         = cyc;
    assign busy       = (r_state != S_IDLE);
    assign adr        = r_adr;
    assign dat_ms     = {8'h00, r_dat};
    assign sel        = 4'hF;
    assign cti        = 3'b000;
    assign bte        = 2'b00;
    assign frame_done = r_frame_done;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state: last pixel beats burst release; enable only matters in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_WRITE;
            S_WRITE: begin
                if (ack) begin
                    if (w_last_px)        w_next = S_IDLE;
                    else if (w_burst_end) w_next = S_PAUSE;
                end
            end
            S_PAUSE: w_next = S_WRITE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pixel position, address/data registers and frame bookkeeping
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_idx        <= '0;
            r_burst_cnt  <= '0;
            r_bar        <= 3'd0;
            r_bar_px     <= '0;
            r_mode       <= 2'd0;
            r_frame_cnt  <= 8'd0;
            r_adr        <= BASE_ADDR;
            r_dat        <= 24'h000000;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_mode      <= mode;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_idx       <= '0;
                        r_burst_cnt <= '0;
                        r_bar       <= 3'd0;
                        r_bar_px    <= '0;
                        r_adr       <= BASE_ADDR;
                        r_dat       <= f_pattern(8'd0, 4'd0, 3'd0, mode, r_frame_cnt);
                    end
                end
                S_WRITE: begin
                    if (ack) begin
                        if (w_last_px) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 8'd1;
                            r_burst_cnt  <= '0;
                        end else begin
                            r_x         <= w_nx;
                            r_y         <= w_ny;
                            r_idx       <= w_nidx;
                            r_bar       <= w_nbar;
                            r_bar_px    <= w_nbar_px;
                            r_burst_cnt <= w_burst_end ? '0 : r_burst_cnt + 1'b1;
                            r_adr       <= BASE_ADDR + (32'(w_nidx) << 2);
                            r_dat       <= f_pattern(8'(w_nx), 4'(w_ny), w_nbar, r_mode, r_frame_cnt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_fb_writer.sv
// Bench for pattern_fb_writer: two instances (16x4/BURST 64 and 16x8/BURST 32) driven one after the other.
// Expected writes are queued per frame from a pixel-level model; a negedge monitor pops on every handshake.
// Frame-level timing (pauses, busy, frame_done) is checked by the stimulus process as frames run.
module tb_pattern_fb_writer;

    typedef struct packed {
        logic [7:0]  dut;
        logic [31:0] adr;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        en       [2];
    logic        ack      [2];
    logic [1:0]  md       [2];
    logic        cyc_o    [2];
    logic        stb_o    [2];
    logic        we_o     [2];
    logic        busy_o   [2];
    logic        fd_o     [2];
    logic [31:0] adr_o    [2];
    logic [31:0] dat_o    [2];
    logic [3:0]  sel_o    [2];
    logic [2:0]  cti_o    [2];
    logic [1:0]  bte_o    [2];

    bit          ack_rand [2];
    int          wr_cnt   [2];
    bit          hold_v   [2];
    logic [31:0] hold_adr [2];
    logic [31:0] hold_dat [2];
    exp_t        q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    pattern_fb_writer #(.HDISP(16), .VDISP(4), .BURST(64), .BASE_ADDR(32'h0)) dut_a (
        .sys_clk(clk), .sys_rst(rst[0]), .enable(en[0]), .mode(md[0]),
        .cyc(cyc_o[0]), .stb(stb_o[0]), .we(we_o[0]), .adr(adr_o[0]), .dat_ms(dat_o[0]),
        .sel(sel_o[0]), .cti(cti_o[0]), .bte(bte_o[0]), .ack(ack[0]),
        .busy(busy_o[0]), .frame_done(fd_o[0])
    );

    pattern_fb_writer #(.HDISP(16), .VDISP(8), .BURST(32), .BASE_ADDR(32'h0)) dut_b (
        .sys_clk(clk), .sys_rst(rst[1]), .enable(en[1]), .mode(md[1]),
        .cyc(cyc_o[1]), .stb(stb_o[1]), .we(we_o[1]), .adr(adr_o[1]), .dat_ms(dat_o[1]),
        .sel(sel_o[1]), .cti(cti_o[1]), .bte(bte_o[1]), .ack(ack[1]),
        .busy(busy_o[1]), .frame_done(fd_o[1])
    );

    function automatic int vd(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic int bl(input int k);
        return (k == 0) ? 64 : 32;
    endfunction

    // Reference pixel for a 16-pixel-wide frame, straight from the pattern definitions
    function automatic logic [31:0] model_pix(input int x, input int y, input int m, input int fc);
        logic [23:0] bars [8];
        logic [7:0]  v;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        case (m)
            0:       return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FFFFFF : 32'h0;
            1:       return {8'h00, bars[x / (16 / 8)]};
            2:       begin v = 8'(x % 256);  return {8'h00, v, v, v}; end
            default: begin v = 8'(fc % 256); return {8'h00, v, v, v}; end
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic push_frame(input int k, input int m, input int fc);
        exp_t e;
        for (int y = 0; y < vd(k); y++) begin
            for (int x = 0; x < 16; x++) begin
                e.dut = 8'(k);
                e.adr = 32'(4 * (y * 16 + x));
                e.dat = model_pix(x, y, m, fc);
                q.push_back(e);
            end
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    // Runs until nfr frame_done pulses; optionally changes mode and drops enable at given cycles
    task automatic run(input int k, input int nfr, input int sw_at, input logic [1:0] sw_mode,
                       input int drop_at, input int exp_pauses);
        int ci      = 0;
        int fds     = 0;
        int pauses  = 0;
        int drops   = 0;
        int last_hs = -10;
        int fstart;
        bit in_frame = 0;
        fstart = wr_cnt[k];
        while (fds < nfr && ci < 4000) begin
            @(negedge clk);
            #1;
            ci++;
            if (ci == sw_at)   md[k] = sw_mode;
            if (ci == drop_at) en[k] = 1'b0;
            if (cyc_o[k]) in_frame = 1;
            if (busy_o[k] && !cyc_o[k]) begin
                pauses++;
                check("pause_pos", 64'(((wr_cnt[k] - fstart) % bl(k) == 0) && (wr_cnt[k] > fstart)), 64'd1);
            end
            if (in_frame && !busy_o[k] && !fd_o[k]) drops++;
            if (fd_o[k]) begin
                fds++;
                in_frame = 0;
                check("frame_writes", 64'(wr_cnt[k] - fstart), 64'(16 * vd(k)));
                check("fd_latency", 64'(ci - last_hs), 64'd1);
                fstart = wr_cnt[k];
            end
            if (cyc_o[k] && stb_o[k] && ack[k]) last_hs = ci;
        end
        if (fds < nfr) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout dut%0d: %0d of %0d frames done", k, fds, nfr);
        end
        check("pause_count", 64'(pauses), 64'(exp_pauses));
        check("busy_drops", 64'(drops), 64'd0);
        @(negedge clk);
        #1;
        check("fd_width", 64'(fd_o[k]), 64'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("idle_after", 64'({cyc_o[k], busy_o[k]}), 64'd0);
        end
    endtask

    // ack driver: constant 1 or 30% random, updated just after each edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                ack[k] = ack_rand[k] ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on each handshake plus hold-stability under stall
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst[k]) begin
                    hold_v[k] = 0;
                end else begin
                    if (hold_v[k] && stb_o[k]) begin
                        check("hold_adr", 64'(adr_o[k]), 64'(hold_adr[k]));
                        check("hold_dat", 64'(dat_o[k]), 64'(hold_dat[k]));
                    end
                    if (cyc_o[k] && stb_o[k] && ack[k]) begin
                        wr_cnt[k]++;
                        if (q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_write dut%0d: adr %0h dat %0h, nothing expected", k, adr_o[k], dat_o[k]);
                        end else begin
                            e = q.pop_front();
                            check("wr_dut", 64'(k), 64'(e.dut));
                            check("wr_adr", 64'(adr_o[k]), 64'(e.adr));
                            check("wr_dat", 64'(dat_o[k]), 64'(e.dat));
                            check("bus_const", 64'({we_o[k], sel_o[k], cti_o[k], bte_o[k]}), 64'({1'b1, 4'hF, 3'b000, 2'b00}));
                        end
                    end
                    hold_v[k]   = stb_o[k] && !ack[k];
                    hold_adr[k] = adr_o[k];
                    hold_dat[k] = dat_o[k];
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; en[k] = 1'b1; md[k] = 2'd0; ack[k] = 1'b1;
            ack_rand[k] = 0; wr_cnt[k] = 0; hold_v[k] = 0;
        end

        // Reset held with enable high: bus idle, address at base
        repeat (3) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                check("reset_state", 64'({cyc_o[k], stb_o[k], busy_o[k], fd_o[k], adr_o[k], dat_o[k]}), 64'd0);
        end

        // 16x4 grid frame, ack always high, enable dropped mid-frame
        push_frame(0, 0, 0);
        at_pos();
        rst[0] = 1'b0;
        run(0, 1, -1, 2'd0, 10, 0);

        // Same frame with random stalls, then a gradient frame
        ack_rand[0] = 1;
        push_frame(0, 0, 1);
        at_pos();
        en[0] = 1'b1;
        run(0, 1, -1, 2'd0, 30, 0);
        push_frame(0, 2, 2);
        at_pos();
        md[0] = 2'd2;
        en[0] = 1'b1;
        run(0, 1, -1, 2'd0, 30, 0);
        ack_rand[0] = 0;
        check("a_queue_drained", 64'(q.size()), 64'd0);

        // 16x8 colour bars then back-to-back solid frame; mode switched mid-frame
        md[1] = 2'd1;
        push_frame(1, 1, 0);
        push_frame(1, 3, 1);
        at_pos();
        rst[1] = 1'b0;
        run(1, 2, 40, 2'd3, 160, 6);

        // Reset after 20 writes abandons the frame; the next frame starts over at base
        push_frame(1, 2, 2);
        at_pos();
        md[1] = 2'd2;
        en[1] = 1'b1;
        base  = wr_cnt[1];
        guard = 0;
        while (wr_cnt[1] - base < 20 && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("reach_write20", 64'(wr_cnt[1] - base), 64'd20);
        at_pos();
        rst[1] = 1'b1;
        at_pos();
        @(negedge clk);
        #1;
        check("midrst_bus", 64'({cyc_o[1], stb_o[1], busy_o[1], fd_o[1]}), 64'd0);
        check("midrst_adr", 64'(adr_o[1]), 64'd0);
        check("midrst_dat", 64'(dat_o[1]), 64'd0);
        q.delete();
        push_frame(1, 2, 0);
        at_pos();
        rst[1] = 1'b0;
        run(1, 1, -1, 2'd0, 20, 3);
        check("b_queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
